// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - valid/ready pipelined adder/subtractor split into STAGES carry slices
// Optional signed saturation of Y on overflow when PIPELINED_ADDER_SAT_EN is defined.
module pipelined_adder #(
    parameter int n      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] Y,
    output logic         cout,
    output logic         ovf
);
    localparam int W = n / STAGES;

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic [n-1:0]      r_sum [STAGES];
    logic [n-1:0]      r_a   [STAGES];
    logic [n-1:0]      r_b   [STAGES];
    logic              r_ovf;

    logic [STAGES-1:0] w_open;
    logic [STAGES-1:0] w_src_v;
    logic [STAGES-1:0] w_src_c;
    logic [n-1:0]      w_src_a   [STAGES];
    logic [n-1:0]      w_src_b   [STAGES];
    logic [n-1:0]      w_src_sum [STAGES];
    logic [n-1:0]      w_nsum    [STAGES];
    logic [W:0]        w_slice   [STAGES];
    logic              w_ovf;

    always_comb begin
        // A stage can take new data if it is empty or everything ahead of it moves this cycle.
        w_open = '0;
        w_open[STAGES-1] = ~r_valid[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_open[k] = ~r_valid[k] | w_open[k+1];
        end

        w_src_v[0]   = in_valid;
        w_src_a[0]   = A;
        w_src_b[0]   = sub ? ~B : B;
        w_src_c[0]   = sub | cin;
        w_src_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_src_v[k]   = r_valid[k-1];
            w_src_a[k]   = r_a[k-1];
            w_src_b[k]   = r_b[k-1];
            w_src_c[k]   = r_carry[k-1];
            w_src_sum[k] = r_sum[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            w_slice[k] = {1'b0, w_src_a[k][k*W +: W]} + {1'b0, w_src_b[k][k*W +: W]}
                       + {{W{1'b0}}, w_src_c[k]};
            w_nsum[k] = w_src_sum[k];
            w_nsum[k][k*W +: W] = w_slice[k][W-1:0];
        end

        w_ovf = (w_src_a[STAGES-1][n-1] == w_src_b[STAGES-1][n-1])
              & (w_nsum[STAGES-1][n-1] != w_src_a[STAGES-1][n-1]);
`ifdef PIPELINED_ADDER_SAT_EN
        if (w_ovf) begin
            w_nsum[STAGES-1] = w_src_a[STAGES-1][n-1] ? {1'b1, {(n-1){1'b0}}}
                                                       : {1'b0, {(n-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_carry <= '0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_open[k]) begin
                    r_valid[k] <= w_src_v[k];
                    if (w_src_v[k]) begin
                        r_sum[k]   <= w_nsum[k];
                        r_carry[k] <= w_slice[k][W];
                        r_a[k]     <= w_src_a[k];
                        r_b[k]     <= w_src_b[k];
                    end
                end
            end
            if (w_open[STAGES-1] && w_src_v[STAGES-1]) begin
                r_ovf <= w_ovf;
            end
        end
    end

    assign in_ready  = w_open[0];
    assign out_valid = r_valid[STAGES-1];
    assign Y         = r_sum[STAGES-1];
    assign cout      = r_carry[STAGES-1];
    assign ovf       = r_ovf;
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's combinational adder.
- Computes A+B+cin or A-B with carry-out and signed overflow flags.
- The N-bit carry chain is split across STAGES register slices.
- Operands and results move on valid/ready handshakes, so the block can sit between the datapath and multi-cycle units without timing-limiting the carry chain.

Parameters:
- n, 32, operand/result width in bits; n % STAGES must equal 0.
- STAGES, 4, pipeline depth = number of carry slices, 1..n; slice width W = n/STAGES.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept operands this cycle
- A  input  n  operand A
- B  input  n  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  1 = A-B (B inverted, carry-in forced 1, cin ignored)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- Y  output  n  result
- cout  output  1  carry-out of bit n-1 (sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: rst_n sampled low at a clk edge clears all stage valid bits and data.
  - out_valid=0, Y=0, cout=0, ovf=0; in_ready=1 after reset.
  - Reset mid-operation discards every in-flight result; no partial output ever appears.
- Input handshake:
  - Transfer occurs when in_valid & in_ready at a clk edge.
  - A, B, cin, sub are sampled only then.
- Output handshake:
  - Result is consumed when out_valid & out_ready.
  - Y/cout/ovf stay stable while out_valid=1 and out_ready=0.
- Stage k (0..STAGES-1):
  - Adds bits [k*W +: W] of A and B' (B' = sub ? ~B : B) plus the carry from stage k-1.
  - Stage 0 carry-in is sub ? 1 : cin.
  - Upper operand slices travel in delay registers; lower result slices are carried forward.
  - Each stage holds: valid bit, partial sum, carry, remaining operand slices, and the MSB signs needed for ovf.
- Advance rule (per stage, bubble-collapsing):
  - Stage k loads from k-1 when stage k is empty or stage k+1 loads from it this cycle.
  - The last stage empties on an output handshake.
  - in_ready = stage 0 empty or stage 0 advancing. in_ready is combinational from state and out_ready; it does not depend on in_valid.
- Latency and throughput:
  - Unstalled latency is exactly STAGES cycles: accepted at edge t, out_valid=1 after edge t+STAGES-1, visible in cycle t+STAGES... i.e. STAGES register stages from input to output.
  - Throughput is 1 op/cycle with out_ready held high.
  - STAGES=1 degenerates to a single registered adder.
- Capacity: STAGES results in flight. When all stages are full and out_ready=0, in_ready=0.
- Simultaneous accept on input and output in the same cycle while full is allowed: no bubble is inserted and no data is lost.
- Results emerge strictly in acceptance order.
- Arithmetic:
  - Y = (A + B' + c0) mod 2^n.
  - cout = bit n of the full sum.
  - ovf = (A[n-1]==B'[n-1]) & (Y[n-1]!=A[n-1]).
  - Wrap-around is the default behaviour.

Optional Feature:
- Macro: PIPELINED_ADDER_SAT_EN.
- Defined:
  - When ovf=1, Y is replaced in the final stage by the signed saturation value: 0x7F..F if A[n-1]=0, else 0x80..0.
  - ovf still reports 1; cout is unchanged.
  - Latency is unchanged (the mux sits inside the last stage).
- Undefined: Y wraps modulo 2^n; no saturation logic is synthesised.

Test Plan:
- Reset: hold rst_n=0 two edges with in_valid=1 -> out_valid=0, Y=0, cout=0, ovf=0, in_ready=1; no output appears after release.
- Carry across all slices (n=32, STAGES=4): A=0xFFFFFFFF, B=1, cin=0, sub=0 -> Y=0x00000000, cout=1, ovf=0, exactly 4 cycles after acceptance.
- Subtract: A=5, B=7, sub=1 -> Y=0xFFFFFFFE, cout=0, ovf=0; then A=7, B=5 -> Y=2, cout=1.
- Signed overflow: A=0x7FFFFFFF, B=1 -> Y=0x80000000, ovf=1 (Y=0x7FFFFFFF, ovf=1 with PIPELINED_ADDER_SAT_EN); A=0x80000000, B=0x80000000 -> Y=0 (sat: 0x80000000), cout=1, ovf=1.
- Back-pressure: stream 10 ops (A=i, B=100*i) with in_valid=1 and out_ready low for 5 cycles -> in_ready drops after 4 accepts; all 10 results arrive in order, Y=101*i, none duplicated; Y is stable while stalled.
- Reset mid-stream: pull rst_n low with 3 ops in flight -> next cycle out_valid=0; after release, a new op 2+3 yields Y=5 with none of the old results.
